// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding, opposite lookup, debounce default.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  // Opposite directions differ only in the MSB of the encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, level debouncer, press-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic resetN,
  input  logic i_raw,
  output logic o_pulse
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Synchronize, count disagreement with the stable level, accept after a full run.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      if (r_sync2 == r_stable) begin
        // any return to the stable level restarts the run
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/joystick_dir_ctrl.sv
// Joystick front end for the snake game: debounced buttons, direction
// request arbitration, pending/commit on move_tick, and start/pause.
module joystick_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_select,
  input  logic       btn_start,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       step,
  output logic       paused,
  output logic       a_pulse,
  output logic       b_pulse,
  output logic       select_pulse
);

  // Index map: 0 up, 1 down, 2 left, 3 right, 4 a, 5 b, 6 select, 7 start
  logic [7:0] w_raw;
  logic [7:0] w_pls;

  assign w_raw = {btn_start, btn_select, btn_b, btn_a,
                  btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 8; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk    (clk),
      .resetN (resetN),
      .i_raw  (w_raw[g]),
      .o_pulse(w_pls[g])
    );
  end

  dir_t r_dir;
  dir_t r_pend_dir;
  logic r_pend_vld;
  logic r_paused;
  logic r_step;

  logic w_req_vld;
  dir_t w_req_dir;
  logic w_commit;
  dir_t w_ref;
  logic w_accept;

  // Pick one direction request per cycle: up > right > down > left.
  always_comb begin
    w_req_vld = 1'b0;
    w_req_dir = UP;
    if (w_pls[0]) begin
      w_req_vld = 1'b1;
      w_req_dir = UP;
    end else if (w_pls[3]) begin
      w_req_vld = 1'b1;
      w_req_dir = RIGHT;
    end else if (w_pls[1]) begin
      w_req_vld = 1'b1;
      w_req_dir = DOWN;
    end else if (w_pls[2]) begin
      w_req_vld = 1'b1;
      w_req_dir = LEFT;
    end
  end

  // A request racing a commit is judged against the direction being committed.
  assign w_commit = move_tick & ~r_paused & r_pend_vld;
  assign w_ref    = w_commit ? r_pend_dir : r_dir;
  assign w_accept = w_req_vld & ~r_paused &
                    (w_req_dir != w_ref) & (w_req_dir != opposite(w_ref));

  // Direction commit, pending request, pause toggle and step strobe.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_dir      <= RIGHT;
      r_pend_dir <= RIGHT;
      r_pend_vld <= 1'b0;
      r_paused   <= 1'b1;
      r_step     <= 1'b0;
    end else begin
      r_step <= move_tick & ~r_paused;
      if (w_pls[7]) begin
        r_paused <= ~r_paused;
      end
      if (w_commit) begin
        r_dir      <= r_pend_dir;
        r_pend_vld <= 1'b0;
      end
      if (r_paused) begin
        r_pend_vld <= 1'b0;
      end else if (w_accept) begin
        r_pend_dir <= w_req_dir;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign dir          = r_dir;
  assign step         = r_step;
  assign paused       = r_paused;
  assign a_pulse      = w_pls[4];
  assign b_pulse      = w_pls[5];
  assign select_pulse = w_pls[6];

endmodule

// File: tb/tb_joystick_dir_ctrl.sv
// Directed bench for joystick_dir_ctrl with a 4-cycle debounce.
module tb_joystick_dir_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] btn;  // 0 up,1 down,2 left,3 right,4 a,5 b,6 select,7 start
  logic       move_tick;
  logic [1:0] dir;
  logic       step;
  logic       paused;
  logic       a_pulse;
  logic       b_pulse;
  logic       select_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  joystick_dir_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .btn_up      (btn[0]),
    .btn_down    (btn[1]),
    .btn_left    (btn[2]),
    .btn_right   (btn[3]),
    .btn_a       (btn[4]),
    .btn_b       (btn[5]),
    .btn_select  (btn[6]),
    .btn_start   (btn[7]),
    .move_tick   (move_tick),
    .dir         (dir),
    .step        (step),
    .paused      (paused),
    .a_pulse     (a_pulse),
    .b_pulse     (b_pulse),
    .select_pulse(select_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    repeat (9) tick();
    btn[idx] = 1'b0;
    repeat (9) tick();
  endtask

  task automatic mt();
    move_tick = 1'b1;
    tick();
    move_tick = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0; btn = '0; move_tick = 1'b0;
    repeat (3) tick();
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL reset_dir got=%b exp=01", dir); end
    checks++; if (paused !== 1'b1) begin failures++; $display("FAIL reset_paused got=%b exp=1", paused); end
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++; if ({a_pulse, b_pulse, select_pulse} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {a_pulse, b_pulse, select_pulse});
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_step_pause();
    move_tick = 1'b1; tick(); move_tick = 1'b0;
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL step_while_paused got=%b exp=0", step); end
    press(7);
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL start_unpause got=%b exp=0", paused); end
    move_tick = 1'b1; tick(); move_tick = 1'b0;
    checks++; if (step !== 1'b1) begin failures++; $display("FAIL step_running got=%b exp=1", step); end
    tick();
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL step_one_cycle got=%b exp=0", step); end
  endtask

  task automatic test_latency();
    int n;
    int seen;
    btn[4] = 1'b1; n = 0;
    while (a_pulse !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 7) begin failures++; $display("FAIL a_latency got=%0d exp=7", n); end
    tick();
    checks++; if (a_pulse !== 1'b0) begin failures++; $display("FAIL a_width got=%b exp=0", a_pulse); end
    btn[4] = 1'b0; seen = 0;
    repeat (12) begin tick(); if (a_pulse) seen = 1; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL a_release_pulse got=%0d exp=0", seen); end
    btn[5] = 1'b1; n = 0;
    while (b_pulse !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 7) begin failures++; $display("FAIL b_latency got=%0d exp=7", n); end
    btn[5] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_up();
    press(0);
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL up_before_tick got=%b exp=01", dir); end
    mt();
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL up_commit got=%b exp=00", dir); end
  endtask

  task automatic test_glitch();
    repeat (20) begin
      btn[2] = 1'b1; repeat (3) tick();
      btn[2] = 1'b0; tick();
    end
    repeat (8) tick();
    mt();
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL glitch_left got=%b exp=00", dir); end
  endtask

  task automatic test_reject();
    press(3); mt();
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL right_commit got=%b exp=01", dir); end
    press(2); mt();
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL left_rejected got=%b exp=01", dir); end
    press(0); press(1); mt();
    checks++; if (dir !== 2'b10) begin failures++; $display("FAIL overwrite_down got=%b exp=10", dir); end
  endtask

  task automatic test_simul();
    press(3); mt();
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL simul_setup got=%b exp=01", dir); end
    btn[0] = 1'b1; btn[2] = 1'b1;
    repeat (9) tick();
    btn[0] = 1'b0; btn[2] = 1'b0;
    repeat (9) tick();
    mt();
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL simul_priority got=%b exp=00", dir); end
  endtask

  task automatic test_commit_race();
    press(3);
    btn[1] = 1'b1;
    repeat (7) tick();
    move_tick = 1'b1; tick(); move_tick = 1'b0;
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL race_commit got=%b exp=01", dir); end
    btn[1] = 1'b0;
    repeat (9) tick();
    mt();
    checks++; if (dir !== 2'b10) begin failures++; $display("FAIL race_new_pending got=%b exp=10", dir); end
  endtask

  task automatic test_pause();
    int n;
    press(2);
    press(7);
    checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_on got=%b exp=1", paused); end
    btn[6] = 1'b1; n = 0;
    while (select_pulse !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 7) begin failures++; $display("FAIL select_paused got=%0d exp=7", n); end
    btn[6] = 1'b0;
    repeat (9) tick();
    press(2);
    press(7);
    checks++; if (paused !== 1'b0) begin failures++; $display("FAIL pause_off got=%b exp=0", paused); end
    mt();
    checks++; if (dir !== 2'b10) begin failures++; $display("FAIL pause_clears_pending got=%b exp=10", dir); end
  endtask

  task automatic test_reset_mid();
    int n;
    press(2);
    btn[1] = 1'b1;
    repeat (3) tick();
    resetN = 1'b0; tick();
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL midrst_dir got=%b exp=01", dir); end
    checks++; if (paused !== 1'b1) begin failures++; $display("FAIL midrst_paused got=%b exp=1", paused); end
    resetN = 1'b1; n = 0;
    while (dut.w_pls[1] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n !== 7) begin failures++; $display("FAIL midrst_down_latency got=%0d exp=7", n); end
    btn[1] = 1'b0;
    repeat (9) tick();
    press(7);
    mt();
    checks++; if (dir !== 2'b01) begin failures++; $display("FAIL midrst_pending got=%b exp=01", dir); end
  endtask

  initial begin
    test_reset();
    test_step_pause();
    test_latency();
    test_up();
    test_glitch();
    test_reject();
    test_simul();
    test_commit_race();
    test_pause();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
